rr_req_arbiter: RTL and testbench

Four-way round-robin request arbiter. It sits directly upstream of the 4-to-2 encoder, and its one-hot grant vector drives the encoder's 4-bit data_in. It guarantees that the encoder only ever sees all-zero or exactly-one-hot input. Each grant is held until the owner releases it or a hold-limit timeout fires.

---
 rtl/arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 33 +++
 rtl/rr_req_arbiter.sv | 94 +++++++++
 tb/tb_rr_req_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin request arbiter.
package arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    localparam int ARB_MAX_HOLD_DEF = 8;

    // Wrap is done explicitly so non-power-of-2 requester counts work.
    function automatic int rr_next_ptr(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, with wrap.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [PW-1:0] idx_o,
    output logic          found_o
);

    int j;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        j        = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) j = j - N;
            if (!found_o && req_i[j]) begin
                found_o = 1'b1;
                idx_o   = PW'(j);
            end
        end
        if (found_o) onehot_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/rr_req_arbiter.sv
// Four-way round-robin arbiter with hold-limit timeout; grant is one-hot or zero
// and always drops for at least one cycle between owners.
module rr_req_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
    parameter int CNT_W    = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         gnt_valid
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    arb_state_t       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    widx_q, widx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic             vld_q, vld_d;

    logic [N-1:0]     pick_oh;
    logic [PW-1:0]    pick_idx;
    logic             pick_found;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .found_o  (pick_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            widx_q  <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            widx_q  <= widx_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        widx_d  = widx_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        vld_d   = vld_q;
        case (state_q)
            ARB_IDLE: begin
                gnt_d = '0;
                vld_d = 1'b0;
                if (pick_found) begin
                    gnt_d   = pick_oh;
                    widx_d  = pick_idx;
                    cnt_d   = CNT_W'(1);
                    vld_d   = 1'b1;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                // Release always passes through IDLE, so the owner's successor
                // is re-picked from the advanced pointer a cycle later.
                if (!req[widx_q] || cnt_q == CNT_W'(MAX_HOLD)) begin
                    gnt_d   = '0;
                    vld_d   = 1'b0;
                    ptr_d   = PW'(rr_next_ptr(int'(widx_q), N));
                    cnt_d   = '0;
                    state_d = ARB_IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign gnt_valid = vld_q;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed bench for rr_req_arbiter (MAX_HOLD=4) with a behavioural 4-to-2 encoder downstream.
module tb_rr_req_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       gnt_valid;

    int checks   = 0;
    int failures = 0;

    rr_req_arbiter #(.N(4), .MAX_HOLD(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] enc(input logic [3:0] d);
        case (d)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic [3:0] exp);
        chk({tag, ".gnt"}, 32'(gnt), 32'(exp));
        chk({tag, ".vld"}, 32'(gnt_valid), 32'(|exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        checks++;
        assert ($onehot0(gnt) && (gnt_valid === |gnt)) else begin
            failures++;
            $error("FAIL invariant observed gnt=%b vld=%b required onehot0 and vld==|gnt", gnt, gnt_valid);
        end
    end

    logic [3:0] rot [21];

    initial begin
        rot = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
                4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000,
                4'b0001};
        rst = 1'b1;
        req = 4'b0000;
        step();
        step();
        chk_gnt("reset", 4'b0000);
        rst = 1'b0;

        // single request, held three edges then dropped
        req = 4'b0001;
        step(); chk_gnt("single.k", 4'b0001);
        step(); chk_gnt("single.k1", 4'b0001);
        step(); chk_gnt("single.k2", 4'b0001);
        req = 4'b0000;
        step(); chk_gnt("single.k3", 4'b0000);
        req = 4'b0001;
        step(); chk_gnt("single.regrant", 4'b0001);
        req = 4'b0000;
        step(); chk_gnt("single.rel", 4'b0000);
        step(); chk_gnt("single.idle", 4'b0000);

        // async reset mid-grant
        req = 4'b0100;
        step(); chk_gnt("rst.pre", 4'b0100);
        #2 rst = 1'b1;
        #1 chk_gnt("rst.async", 4'b0000);
        step(); chk_gnt("rst.held", 4'b0000);
        rst = 1'b0;
        step(); chk_gnt("rst.first", 4'b0100);
        req = 4'b0000;
        step(); chk_gnt("rst.rel", 4'b0000);

        // rotation with timeout, wrap 3->0, encoder follows index
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 21; i++) begin
            step();
            chk_gnt($sformatf("rot[%0d]", i), rot[i]);
            if (rot[i] != 4'b0000)
                chk($sformatf("enc[%0d]", i), 32'(enc(gnt)), 32'((i / 5) % 4));
        end
        req = 4'b0000;
        step(); chk_gnt("rot.rel", 4'b0000);

        // priority after release (ptr now 1)
        req = 4'b0100;
        step(); chk_gnt("prio.g2", 4'b0100);
        req = 4'b1011;
        step(); chk_gnt("prio.rel2", 4'b0000);
        step(); chk_gnt("prio.g3", 4'b1000);
        req = 4'b0011;
        step(); chk_gnt("prio.rel3", 4'b0000);
        step(); chk_gnt("prio.g0", 4'b0001);
        req = 4'b0000;
        step(); chk_gnt("prio.rel0", 4'b0000);

        // contention ignored while requester 1 owns the grant
        req = 4'b0010;
        step(); chk_gnt("cont.g1", 4'b0010);
        req = 4'b1011;
        step(); chk_gnt("cont.t1", 4'b0010);
        req = 4'b0010;
        step(); chk_gnt("cont.t2", 4'b0010);
        req = 4'b1000;
        step(); chk_gnt("cont.rel", 4'b0000);
        step(); chk_gnt("cont.g3", 4'b1000);
        req = 4'b0000;
        step(); chk_gnt("cont.end", 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
